ivector_heard_serializer: RTL and testbench

- Downstream consumer of the vector-dispatch block's `heard(meth, v)` indication.
- Buffers indications in a small FIFO and serialises each into a two-beat word stream: header, then payload.
- The stream goes to the host-side pipe (portal output FIFO).
- Rejects out-of-range method indices and keeps a sticky error flag.

---
 rtl/ivector_heard_serializer.sv | 121 ++++++++++++
 tb/tb_ivector_heard_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ivector_heard_serializer.sv
// ivector_heard_serializer
// Buffers heard(meth, v) indications in a small FIFO and streams each one to
// the host-side pipe as two beats: a header {meth[15:0], 16'h0001} followed by
// the payload word. Out-of-range method indices are dropped and raise a sticky
// bad_meth flag.
//
// Optional build macro: IVECTOR_HEARD_SERIALIZER_STATS_EN
//   When defined, adds msg_count (completed messages, wrapping) and
//   drop_count (dropped indications, saturating) outputs.

module ivector_heard_serializer #(
  parameter int DEPTH      = 4,
  parameter int METH_COUNT = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        heard__ENA,
  input  logic [31:0] heard_meth,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        pipe_enq__ENA,
  output logic [31:0] pipe_enq_v,
  input  logic        pipe_enq__RDY,
`ifdef IVECTOR_HEARD_SERIALIZER_STATS_EN
  output logic [31:0] msg_count,
  output logic [15:0] drop_count,
`endif
  output logic        bad_meth
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  localparam logic PH_HDR = 1'b0;
  localparam logic PH_PAY = 1'b1;

  logic [15:0]   mem_meth [DEPTH];
  logic [31:0]   mem_v    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          phase;

  logic          accept;
  logic          in_range;
  logic          push;
  logic          beat;
  logic          pop;

  // Handshake decode; RDY/ENA depend only on registered count.
  assign heard__RDY    = (count != CNT_FULL);
  assign pipe_enq__ENA = (count != CNT_ZERO);
  assign accept        = heard__ENA & heard__RDY;
  assign in_range      = (heard_meth < 32'(METH_COUNT));
  assign push          = accept & in_range;
  assign beat          = pipe_enq__ENA & pipe_enq__RDY;
  assign pop           = beat & (phase == PH_PAY);

  // Entry storage: written on every valid push.
  // NOTE: the FIFO array has no reset; entries are only read once count says
  // they were written, so clearing them would cost flops for no behaviour.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_meth[wr_ptr] <= heard_meth[15:0];
      mem_v[wr_ptr]    <= heard_v;
    end
  end

  // Pointers, occupancy, beat phase and the sticky error flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= PH_HDR;
      bad_meth <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;

      if (beat) phase <= (phase == PH_HDR) ? PH_PAY : PH_HDR;

      if (accept && !in_range) bad_meth <= 1'b1;
    end
  end

  // Output beat mux: header, payload, or zero when idle.
  // NOTE: the default assignment first keeps this block free of inferred
  // latches whichever branch is taken.
  always_comb begin
    pipe_enq_v = 32'h0000_0000;
    if (pipe_enq__ENA) begin
      if (phase == PH_HDR) pipe_enq_v = {mem_meth[rd_ptr], 16'h0001};
      else                 pipe_enq_v = mem_v[rd_ptr];
    end
  end

`ifdef IVECTOR_HEARD_SERIALIZER_STATS_EN
  // Statistics: completed messages (wrapping) and drops (saturating).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      msg_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pop) msg_count <= msg_count + 32'd1;
      if (accept && !in_range && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Scoreboard bench for ivector_heard_serializer: stimulus pushes expected
// beats into a queue, a negedge monitor compares every presented beat.

module tb_ivector_heard_serializer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        heard__ENA = 1'b0;
  logic [31:0] heard_meth = '0;
  logic [31:0] heard_v = '0;
  logic        heard__RDY;
  logic        pipe_enq__ENA;
  logic [31:0] pipe_enq_v;
  logic        pipe_enq__RDY = 1'b0;
  logic        bad_meth;
`ifdef IVECTOR_HEARD_SERIALIZER_STATS_EN
  logic [31:0] msg_count;
  logic [15:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  ivector_heard_serializer #(.DEPTH(4), .METH_COUNT(10)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .heard__ENA   (heard__ENA),
    .heard_meth   (heard_meth),
    .heard_v      (heard_v),
    .heard__RDY   (heard__RDY),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v   (pipe_enq_v),
    .pipe_enq__RDY(pipe_enq__RDY),
`ifdef IVECTOR_HEARD_SERIALIZER_STATS_EN
    .msg_count    (msg_count),
    .drop_count   (drop_count),
`endif
    .bad_meth     (bad_meth)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented beat against the scoreboard head.
  always @(negedge CLK) begin
    if (nRST) begin
      if (pipe_enq__ENA) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", pipe_enq_v, 32'hxxxx_xxxx);
        end else begin
          check("beat", pipe_enq_v, exp_q[0]);
          if (pipe_enq__RDY) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_data_zero", pipe_enq_v, 32'h0);
      end
    end
  end

  // Issue one indication starting at posedge+1; returns at posedge+1.
  task automatic push(input logic [31:0] meth, input logic [31:0] v);
    check("rdy_before_push", {31'b0, heard__RDY}, 32'd1);
    if (heard__RDY) begin
      heard_meth = meth;
      heard_v    = v;
      heard__ENA = 1'b1;
      if (meth < 32'd10) begin
        exp_q.push_back({meth[15:0], 16'h0001});
        exp_q.push_back(v);
      end
      @(posedge CLK);
      #1 heard__ENA = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || pipe_enq__ENA) && n < 50) begin
      @(posedge CLK);
      #1 n++;
    end
    check("drain_done", {31'b0, (exp_q.size() == 0 && !pipe_enq__ENA)}, 32'd1);
  endtask

  task automatic do_reset();
    #2 nRST = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    check("rst_rdy", {31'b0, heard__RDY}, 32'd1);
    check("rst_ena", {31'b0, pipe_enq__ENA}, 32'd0);
    check("rst_data", pipe_enq_v, 32'h0);
    check("rst_bad", {31'b0, bad_meth}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    check("rst_rdy", {31'b0, heard__RDY}, 32'd1);
    check("rst_ena", {31'b0, pipe_enq__ENA}, 32'd0);
    check("rst_data", pipe_enq_v, 32'h0);
    check("rst_bad", {31'b0, bad_meth}, 32'd0);

    // Single message with one-cycle header latency.
    pipe_enq__RDY = 1'b1;
    push(32'd3, 32'hDEAD_BEEF);
    check("single_hdr_latency", {pipe_enq__ENA, 31'b0} | (pipe_enq_v & 32'h7FFF_FFFF),
          32'h8003_0001);
    wait_drain();

    // Backpressure: header held for five cycles, then one header and payload.
    pipe_enq__RDY = 1'b0;
    push(32'd7, 32'h1234_5678);
    repeat (5) @(posedge CLK);
    #1 check("bp_hold", pipe_enq_v, 32'h0007_0001);
    pipe_enq__RDY = 1'b1;
    wait_drain();

    // Fill and drain.
    pipe_enq__RDY = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(i), 32'h100 + 32'(i));
    check("full_rdy_low", {31'b0, heard__RDY}, 32'd0);
    pipe_enq__RDY = 1'b1;
    @(posedge CLK);
    #1 check("rdy_low_after_hdr", {31'b0, heard__RDY}, 32'd0);
    @(posedge CLK);
    #1 check("rdy_high_after_pop", {31'b0, heard__RDY}, 32'd1);
    wait_drain();

    // Bad method, then a valid one at the upper boundary.
    do_reset();
    pipe_enq__RDY = 1'b1;
    push(32'd10, 32'd1);
    repeat (2) @(posedge CLK);
    #1 check("bad_no_beat", {31'b0, pipe_enq__ENA}, 32'd0);
    check("bad_flag_set", {31'b0, bad_meth}, 32'd1);
    push(32'd9, 32'd2);
    wait_drain();
    check("bad_flag_sticky", {31'b0, bad_meth}, 32'd1);
`ifdef IVECTOR_HEARD_SERIALIZER_STATS_EN
    check("drop_count", {16'b0, drop_count}, 32'd1);
    check("msg_count", msg_count, 32'd1);
`endif

    // Reset mid-message with two entries queued.
    pipe_enq__RDY = 1'b0;
    push(32'd4, 32'hA);
    push(32'd5, 32'hB);
    pipe_enq__RDY = 1'b1;
    @(posedge CLK);
    #1 pipe_enq__RDY = 1'b0;
    #2 nRST = 1'b0;
    #1 check("midrst_ena", {31'b0, pipe_enq__ENA}, 32'd0);
    check("midrst_rdy", {31'b0, heard__RDY}, 32'd1);
    check("midrst_bad", {31'b0, bad_meth}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    pipe_enq__RDY = 1'b1;
    push(32'd1, 32'h55);
    check("postrst_hdr", pipe_enq_v, 32'h0001_0001);
    wait_drain();

    // Simultaneous push and pop at DEPTH-1, across pointer wrap.
    pipe_enq__RDY = 1'b0;
    for (int i = 0; i < 3; i++) push(32'(i), 32'h200 + 32'(i));
    pipe_enq__RDY = 1'b1;
    @(posedge CLK);
    #1 push(32'd3, 32'h203);
    pipe_enq__RDY = 1'b0;
    check("simul_rdy_kept", {31'b0, heard__RDY}, 32'd1);
    push(32'd4, 32'h204);
    check("simul_then_full", {31'b0, heard__RDY}, 32'd0);
    pipe_enq__RDY = 1'b1;
    wait_drain();

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
